// File: rtl/nonrestoring_divider_pkg.sv
// Shared definitions for the non-restoring divider: FSM state encodings
// and the default operand width.
package nonrestoring_divider_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ITER    = 2'd1,
        CORRECT = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/divider_datapath.sv
// Partial-remainder (A), quotient (Q) and divisor (M) registers, the
// add/subtract unit and the iteration counter of the divider.
module divider_datapath
    import nonrestoring_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             correct,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             sign,
    output logic             count_is_one,
    output logic [WIDTH-1:0] q_val,
    output logic [WIDTH-1:0] r_raw,
    output logic [WIDTH-1:0] r_fix
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH:0]   a_q;
    logic [WIDTH:0]   m_q;
    logic [WIDTH-1:0] q_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   addsub;
    logic [WIDTH:0]   a_plus_m;

    // A negative partial remainder is repaired by adding M on the next step
    assign shifted  = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign addsub   = a_q[WIDTH] ? shifted + m_q : shifted - m_q;
    assign a_plus_m = a_q + m_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            m_q   <= '0;
            q_q   <= '0;
            cnt_q <= '0;
        end else if (load) begin
            a_q   <= '0;
            m_q   <= {1'b0, divisor};
            q_q   <= dividend;
            cnt_q <= CW'(WIDTH);
        end else if (step) begin
            a_q   <= addsub;
            q_q   <= {q_q[WIDTH-2:0], ~addsub[WIDTH]};
            cnt_q <= cnt_q - CW'(1);
        end else if (correct && a_q[WIDTH]) begin
            a_q <= a_plus_m;
        end
    end

    assign sign         = a_q[WIDTH];
    assign count_is_one = (cnt_q == CW'(1));
    assign q_val        = q_q;
    assign r_raw        = a_q[WIDTH-1:0];
    assign r_fix        = a_plus_m[WIDTH-1:0];

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential unsigned non-restoring divider, one quotient bit per clock,
// with the same start/done handshake as the Booth multiplier.
module nonrestoring_divider
    import nonrestoring_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t state_q;
    state_t state_d;

    logic load;
    logic step;
    logic correct;
    logic ld_res;
    logic ld_zero;

    logic             sign;
    logic             count_is_one;
    logic [WIDTH-1:0] q_val;
    logic [WIDTH-1:0] r_raw;
    logic [WIDTH-1:0] r_fix;

    divider_datapath #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .step         (step),
        .correct      (correct),
        .dividend     (dividend),
        .divisor      (divisor),
        .sign         (sign),
        .count_is_one (count_is_one),
        .q_val        (q_val),
        .r_raw        (r_raw),
        .r_fix        (r_fix)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        correct = 1'b0;
        ld_res  = 1'b0;
        ld_zero = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (divisor != '0) begin
                        load    = 1'b1;
                        state_d = ITER;
                    end else begin
                        ld_zero = 1'b1;
                        state_d = DONE;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                step = 1'b1;
                if (count_is_one) state_d = CORRECT;
            end
            CORRECT: begin
                correct = 1'b1;
                ld_res  = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Results only move when an operation finishes or a zero divisor is seen
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (ld_zero) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
        end else if (ld_res) begin
            quotient    <= q_val;
            remainder   <= sign ? r_fix : r_raw;
            div_by_zero <= 1'b0;
        end
    end

    assign busy = (state_q == ITER) || (state_q == CORRECT);
    assign done = (state_q == DONE);

endmodule
